// File: rtl/iram_mon_arbiter.sv
// Shares the instruction RAM port between CPU fetch and the debug monitor, stalling the
// pipeline around monitor accesses and rationing monitor bursts while the CPU runs.
module iram_mon_arbiter #(
  parameter int unsigned IWIDTH    = 12,
  parameter int unsigned BURST_MAX = 8,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_run,
  input  logic              pipe_idle,
  input  logic              mon_req,
  input  logic              mon_we,
  input  logic [IWIDTH-1:0] mon_adr,
  input  logic [31:0]       mon_wdata,
  output logic              mon_busy,
  output logic              mon_ack,
  output logic [31:0]       mon_rdata,
  output logic              stall_mon,
  output logic              i_read_sel,
  output logic [IWIDTH-1:0] i_ram_radr,
  output logic [IWIDTH-1:0] i_ram_wadr,
  output logic [31:0]       i_ram_wdata,
  output logic              i_ram_wen,
  input  logic [31:0]       i_ram_rdata
);

  localparam int unsigned CntW = $clog2(BURST_MAX + 1);
  localparam int unsigned GapW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    StIdle, StHold, StWrite, StRead, StRdata, StPost, StGap
  } state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [CntW-1:0]     r_cnt;
  logic [GapW-1:0]     r_gap;
  logic                r_we;
  logic [IWIDTH-1:0]   r_adr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_stall;
  logic                r_ack;
  logic                r_rsel;
  logic                r_wen;
  logic                w_full;
  logic                w_busy;
  logic                w_accept;

  assign w_full   = (r_cnt == CntW'(BURST_MAX));
  assign w_busy   = !((r_state == StIdle) || ((r_state == StPost) && !w_full));
  assign w_accept = mon_req && !w_busy;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_d = cpu_run ? StHold : (mon_we ? StWrite : StRead);
      end
      StHold: begin
        if (pipe_idle) w_state_d = r_we ? StWrite : StRead;
      end
      StWrite: w_state_d = StPost;
      StRead:  w_state_d = StRdata;
      StRdata: w_state_d = StPost;
      StPost: begin
        if (w_accept)             w_state_d = mon_we ? StWrite : StRead;
        else if (w_full && cpu_run) w_state_d = StGap;
        else                      w_state_d = StIdle;
      end
      StGap: begin
        if (r_gap == '0) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they are clean decodes of r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_stall <= 1'b0;
      r_ack   <= 1'b0;
      r_rsel  <= 1'b0;
      r_wen   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_we    <= mon_we;
        r_adr   <= mon_adr;
        r_wdata <= mon_wdata;
      end
      if (w_accept && cpu_run) begin
        r_cnt <= r_cnt + CntW'(1);
      end else if ((w_state_d == StIdle) || (w_state_d == StGap)) begin
        r_cnt <= '0;
      end
      if ((w_state_d == StGap) && (r_state != StGap)) begin
        r_gap <= GapW'(GAP_CYC - 1);
      end else if (r_gap != '0) begin
        r_gap <= r_gap - GapW'(1);
      end
      if (r_state == StRdata) r_rdata <= i_ram_rdata;
      // Stall only for windows that began with the CPU running; chained accesses keep it.
      r_stall <= (w_state_d == StHold) ||
                 (r_stall && (w_state_d inside {StWrite, StRead, StRdata, StPost}));
      r_ack   <= (w_state_d == StPost);
      r_rsel  <= (w_state_d inside {StRead, StRdata});
      r_wen   <= (w_state_d == StWrite);
    end
  end

  assign mon_busy    = w_busy;
  assign mon_ack     = r_ack;
  assign mon_rdata   = r_rdata;
  assign stall_mon   = r_stall;
  assign i_read_sel  = r_rsel;
  assign i_ram_radr  = r_adr;
  assign i_ram_wadr  = r_adr;
  assign i_ram_wdata = r_wdata;
  assign i_ram_wen   = r_wen;

endmodule

// File: tb/tb_iram_mon_arbiter.sv
// Bench for iram_mon_arbiter: directed vector table, corner sequences and a randomized
// run against a transaction-level scoreboard with an IRAM model.
module tb_iram_mon_arbiter;

  localparam int IW = 12;
  localparam int BM = 8;
  localparam int GC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_run, pipe_idle, mon_req, mon_we;
  logic [IW-1:0] mon_adr;
  logic [31:0]   mon_wdata;
  logic          mon_busy, mon_ack, stall_mon, i_read_sel, i_ram_wen;
  logic [31:0]   mon_rdata, i_ram_wdata, i_ram_rdata;
  logic [IW-1:0] i_ram_radr, i_ram_wadr;

  always #5 clk = ~clk;

  iram_mon_arbiter #(.IWIDTH(IW), .BURST_MAX(BM), .GAP_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_run(cpu_run), .pipe_idle(pipe_idle),
    .mon_req(mon_req), .mon_we(mon_we), .mon_adr(mon_adr), .mon_wdata(mon_wdata),
    .mon_busy(mon_busy), .mon_ack(mon_ack), .mon_rdata(mon_rdata), .stall_mon(stall_mon),
    .i_read_sel(i_read_sel), .i_ram_radr(i_ram_radr), .i_ram_wadr(i_ram_wadr),
    .i_ram_wdata(i_ram_wdata), .i_ram_wen(i_ram_wen), .i_ram_rdata(i_ram_rdata)
  );

  function automatic logic [31:0] init_word(input logic [IW-1:0] a);
    return 32'hA500_0000 | {20'h0, a};
  endfunction

  // Synchronous IRAM: read data one cycle after address; unwritten words hold init_word().
  logic [31:0] ram [int];
  int unsigned n_wen = 0;
  always @(posedge clk) begin
    i_ram_rdata <= ram.exists(int'(i_ram_radr)) ? ram[int'(i_ram_radr)] : init_word(i_ram_radr);
    if (i_ram_wen) begin
      ram[int'(i_ram_wadr)] = i_ram_wdata;
      n_wen = n_wen + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {31'h0, act}, {31'h0, exp});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string p);
    chkb({p, "_stall"}, stall_mon, 1'b0);
    chkb({p, "_busy"}, mon_busy, 1'b0);
    chkb({p, "_ack"}, mon_ack, 1'b0);
    chkb({p, "_rsel"}, i_read_sel, 1'b0);
    chkb({p, "_wen"}, i_ram_wen, 1'b0);
    chk({p, "_radr"}, 32'(i_ram_radr), 32'h0);
    chk({p, "_wadr"}, 32'(i_ram_wadr), 32'h0);
    chk({p, "_wdata"}, i_ram_wdata, 32'h0);
    chk({p, "_rdata"}, mon_rdata, 32'h0);
  endtask

  // Scoreboard for the randomized run: one outstanding command at most, tracked by age.
  typedef struct {
    logic          we;
    logic [IW-1:0] adr;
    logic [31:0]   wdata;
    logic [31:0]   exp;
    bit            held;
    int            age;
    bit            wen_seen;
  } cmd_t;

  cmd_t        m_q[$];
  logic [31:0] m_mem [int];
  int          m_cnt = 0;
  int          m_gap = 0;
  bit          m_win_stall = 1'b0;
  logic [31:0] m_last = 32'h0;

  task automatic rnd_step(input bit drive);
    bit   idle_cyc, ack_seen, busy_obs;
    cmd_t c;
    tick();
    busy_obs = mon_busy;
    ack_seen = mon_ack;
    idle_cyc = (m_q.size() == 0) && (m_gap == 0);
    if (m_q.size() > 0) m_q[0].age = m_q[0].age + 1;
    if (m_gap > 0) begin
      chkb("r_gap_busy", busy_obs, 1'b1);
      chkb("r_gap_stall", stall_mon, 1'b0);
      chkb("r_gap_ack", ack_seen, 1'b0);
      chkb("r_gap_wen", i_ram_wen, 1'b0);
    end else if (m_q.size() == 0) begin
      chkb("r_idle_busy", busy_obs, 1'b0);
      chkb("r_idle_stall", stall_mon, 1'b0);
      chkb("r_idle_ack", ack_seen, 1'b0);
      chkb("r_idle_wen", i_ram_wen, 1'b0);
      chkb("r_idle_rsel", i_read_sel, 1'b0);
      m_cnt = 0;
    end else begin
      chkb("r_stall", stall_mon, m_win_stall);
      if (i_ram_wen) begin
        chkb("r_wen_we", m_q[0].we, 1'b1);
        chk("r_wadr", 32'(i_ram_wadr), 32'(m_q[0].adr));
        chk("r_wdata", i_ram_wdata, m_q[0].wdata);
        m_q[0].wen_seen = 1'b1;
      end
      if (ack_seen) begin
        c = m_q.pop_front();
        chkb("r_post_busy", busy_obs, m_cnt == BM);
        if (!c.we) m_last = c.exp;
        chk("r_rdata", mon_rdata, m_last);
        if (c.we) chkb("r_wen_seen", c.wen_seen, 1'b1);
        if (!c.held) chk("r_lat", 32'(c.age), c.we ? 32'd2 : 32'd3);
        else chkb("r_lat_hold", c.age >= (c.we ? 3 : 4), 1'b1);
      end else begin
        chkb("r_busy", busy_obs, 1'b1);
        chkb("r_stuck", m_q[0].age > 64, 1'b0);
      end
    end
    if (m_gap > 0) m_gap--;
    if (drive) begin
      if ($urandom_range(15) == 0) cpu_run = ~cpu_run;
      pipe_idle = ($urandom_range(3) != 0);
      mon_req   = ($urandom_range(2) == 0);
      mon_we    = 1'($urandom_range(1));
      mon_adr   = 12'h800 | 12'($urandom_range(15));
      mon_wdata = $urandom;
    end else begin
      mon_req = 1'b0;
    end
    if (ack_seen && (m_cnt == BM) && cpu_run) m_gap = GC;
    if (mon_req && !busy_obs) begin
      c.we       = mon_we;
      c.adr      = mon_adr;
      c.wdata    = mon_wdata;
      c.exp      = m_mem.exists(int'(mon_adr)) ? m_mem[int'(mon_adr)] : init_word(mon_adr);
      c.held     = idle_cyc && cpu_run;
      c.age      = 0;
      c.wen_seen = 1'b0;
      if (mon_we) m_mem[int'(mon_adr)] = mon_wdata;
      if (idle_cyc) m_win_stall = cpu_run;
      if (cpu_run) m_cnt++;
      m_q.push_back(c);
    end
  endtask

  typedef struct {
    logic          we;
    logic [IW-1:0] adr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    int            lat;
  } vec_t;

  vec_t vt [8];

  initial begin
    int          ack_c, wen_c, a_wen, a_ack, issued, acks, gap_len, issue9_c, c_acks;
    int unsigned wen0;
    bit          st_seen, in_gap, ack8_busy, ack8_stall, st_after9;
    bit [15:0]   a_st;
    logic [31:0] c_rd;

    vt[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 32'h0000_0000, 2};
    vt[1] = '{1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 3};
    vt[2] = '{1'b1, 12'hFFF, 32'h12345678, 32'hDEADBEEF, 2};
    vt[3] = '{1'b0, 12'hFFF, 32'h0,        32'h12345678, 3};
    vt[4] = '{1'b0, 12'h123, 32'h0,        32'hA500_0123, 3};
    vt[5] = '{1'b1, 12'h000, 32'h0000_0001, 32'hA500_0123, 2};
    vt[6] = '{1'b0, 12'h000, 32'h0,        32'h0000_0001, 3};
    vt[7] = '{1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 3};

    cpu_run = 1'b0; pipe_idle = 1'b0; mon_req = 1'b0; mon_we = 1'b0;
    mon_adr = '0; mon_wdata = '0;
    #1 chk_all_zero("rst");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("rst_rel");

    // Vector table, CPU halted: no stall, fixed latency.
    for (int i = 0; i < 8; i++) begin
      ack_c = -1; wen_c = -1; st_seen = 1'b0;
      cpu_run = 1'b0; mon_req = 1'b1; mon_we = vt[i].we;
      mon_adr = vt[i].adr; mon_wdata = vt[i].wdata;
      for (int c = 1; c <= 8 && ack_c < 0; c++) begin
        tick(); mon_req = 1'b0;
        if (stall_mon) st_seen = 1'b1;
        if (i_ram_wen) begin
          wen_c = c;
          chk("t_wadr", 32'(i_ram_wadr), 32'(vt[i].adr));
          chk("t_wdata", i_ram_wdata, vt[i].wdata);
        end
        if (mon_ack) begin
          ack_c = c;
          chk("t_rdata", mon_rdata, vt[i].exp_rdata);
          chkb("t_post_busy", mon_busy, 1'b0);
        end
      end
      chk("t_ack_lat", ack_c, vt[i].lat);
      chk("t_wen_cyc", wen_c, vt[i].we ? 1 : -1);
      chkb("t_no_stall", st_seen, 1'b0);
      tick();
    end

    // CPU running, pipeline slow to quiesce.
    cpu_run = 1'b1; pipe_idle = 1'b0;
    mon_req = 1'b1; mon_we = 1'b1; mon_adr = 12'h020; mon_wdata = 32'h0BAD_F00D;
    a_wen = -1; a_ack = -1; a_st = '0;
    for (int c = 1; c <= 12; c++) begin
      tick(); mon_req = 1'b0;
      pipe_idle = (c >= 4);
      a_st[c] = stall_mon;
      if (i_ram_wen) a_wen = c;
      if (mon_ack) a_ack = c;
    end
    chkb("a_stall_p1", a_st[1], 1'b1);
    chkb("a_stall_p4", a_st[4], 1'b1);
    chk("a_wen_cyc", a_wen, 5);
    chk("a_ack_cyc", a_ack, 6);
    chkb("a_stall_ack", a_st[6], 1'b1);
    chkb("a_stall_drop", a_st[7], 1'b0);
    chk("a_mem", ram.exists(32'h020) ? ram[32'h020] : 32'h0, 32'h0BAD_F00D);

    // Ten chained writes with the CPU running: burst limit, gap, then a fresh window.
    cpu_run = 1'b1; pipe_idle = 1'b1; wen0 = n_wen;
    mon_req = 1'b1; mon_we = 1'b1; mon_adr = 12'h100; mon_wdata = 32'hC0DE_0000;
    issued = 1; acks = 0; gap_len = 0; issue9_c = -10; in_gap = 1'b0;
    ack8_busy = 1'b0; ack8_stall = 1'b0; st_after9 = 1'b0;
    for (int c = 1; c <= 200 && acks < 10; c++) begin
      tick(); mon_req = 1'b0;
      if (c == issue9_c + 1) st_after9 = stall_mon;
      if (in_gap) begin
        if (mon_busy && !stall_mon) gap_len++;
        else in_gap = 1'b0;
      end
      if (mon_ack) begin
        acks++;
        if (acks == 8) begin
          ack8_busy = mon_busy; ack8_stall = stall_mon; in_gap = 1'b1;
        end
      end
      if (issued < 10 && (!mon_busy || (mon_ack && acks == 8))) begin
        mon_req = 1'b1; mon_we = 1'b1;
        mon_adr = 12'h100 + 12'(issued); mon_wdata = 32'hC0DE_0000 + 32'(issued);
        if (!mon_busy) begin
          if (issued == 8) issue9_c = c;
          issued++;
        end
      end
    end
    mon_req = 1'b0;
    chk("b_acks", acks, 10);
    chkb("b_ack8_busy", ack8_busy, 1'b1);
    chkb("b_ack8_stall", ack8_stall, 1'b1);
    chk("b_gap_len", gap_len, GC);
    chkb("b_rehold_stall", st_after9, 1'b1);
    chk("b_wen_cnt", n_wen - wen0, 10);
    for (int i = 0; i < 10; i++)
      chk("b_mem", ram.exists(32'h100 + i) ? ram[32'h100 + i] : 32'h0, 32'hC0DE_0000 + 32'(i));
    tick(); tick();

    // Request during READ is dropped without an ack.
    cpu_run = 1'b0; wen0 = n_wen;
    mon_req = 1'b1; mon_we = 1'b0; mon_adr = 12'h010;
    tick();
    chkb("c_busy_read", mon_busy, 1'b1);
    mon_req = 1'b1; mon_we = 1'b1; mon_adr = 12'h010; mon_wdata = 32'h5555_5555;
    c_acks = 0; c_rd = 32'h0;
    for (int c = 2; c <= 10; c++) begin
      tick(); mon_req = 1'b0;
      if (mon_ack) begin
        c_acks++; c_rd = mon_rdata;
      end
    end
    chk("c_acks", c_acks, 1);
    chk("c_rdata", c_rd, 32'hDEADBEEF);
    chk("c_no_wen", n_wen - wen0, 0);
    chk("c_mem", ram.exists(32'h010) ? ram[32'h010] : 32'h0, 32'hDEADBEEF);

    // Asynchronous reset while waiting in HOLD.
    cpu_run = 1'b1; pipe_idle = 1'b0; wen0 = n_wen;
    mon_req = 1'b1; mon_we = 1'b1; mon_adr = 12'h030; mon_wdata = 32'h7777_7777;
    tick(); mon_req = 1'b0;
    chkb("d_stall_hold", stall_mon, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("d");
    pipe_idle = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("d_no_wen", n_wen - wen0, 0);
    chkb("d_mem_untouched", ram.exists(32'h030), 1'b0);
    chkb("d_idle_busy", mon_busy, 1'b0);
    chkb("d_idle_stall", stall_mon, 1'b0);

    // Randomized traffic against the scoreboard.
    cpu_run = 1'b0;
    for (int k = 0; k < 3000; k++) rnd_step(1'b1);
    for (int k = 0; k < 100 && (m_q.size() > 0 || m_gap > 0); k++) rnd_step(1'b0);
    chk("r_drained", m_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
